// File: rtl/sprite_instruction_scheduler.sv
// Sprite instruction scheduler: buffers custom-instruction writes, retires them in order.
// Optional WRITE_COUNTER_EN adds a 16-bit retired-write counter to the status word.
module sprite_instruction_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int MEM_ADDR_W = 14,
  parameter int COLOR_W    = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           dataA,
  input  logic [31:0]           dataB,
  input  logic                  vblank,
  output logic                  done,
  output logic [31:0]           result,
  output logic                  busy,
  output logic                  reg_wr_en,
  output logic                  reg_wr_sel,
  output logic [4:0]            reg_wr_addr,
  output logic [31:0]           reg_wr_data,
  output logic                  mem_wr_en,
  output logic [MEM_ADDR_W-1:0] mem_wr_addr,
  output logic [COLOR_W-1:0]    mem_wr_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = MEM_ADDR_W + 4;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC} state_t;

  state_t state_q, state_d;
  logic pend_q, pend_d;
  logic [31:0] pa_q, pa_d, pb_q, pb_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0] op_q, op_d;
  logic done_q, done_d;
  logic [31:0] result_q, result_d;
  logic reg_en_q, reg_en_d, reg_sel_q, reg_sel_d;
  logic [4:0] reg_addr_q, reg_addr_d;
  logic [31:0] reg_data_q, reg_data_d;
  logic mem_en_q, mem_en_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [COLOR_W-1:0] mem_data_q, mem_data_d;
  logic [15:0] wc;

  logic [AW-1:0] fifo_a_q [FIFO_DEPTH];
  logic [31:0]   fifo_b_q [FIFO_DEPTH];
  logic [AW-1:0] head_a;
  logic [31:0]   head_b;

  logic full, empty, is_stat, push, answer, pop;
  logic unused_bits;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign is_stat = (pa_q[1:0] == 2'b11);
  assign push    = pend_q & ~is_stat & ~full;
  assign answer  = pend_q & (is_stat | ~full);
  assign pop     = (state_q == LOAD);
  assign head_a  = fifo_a_q[rd_ptr_q];
  assign head_b  = fifo_b_q[rd_ptr_q];
  assign unused_bits = ^{pa_q[31:AW], pa_q[3:2], head_a[3:2]};

`ifdef WRITE_COUNTER_EN
  logic [15:0] wcnt_q, wcnt_d;
  assign wc = wcnt_q;
  assign wcnt_d = wcnt_q + 16'(reg_en_q | mem_en_q);
  always_ff @(posedge clk) begin
    if (reset) wcnt_q <= '0;
    else       wcnt_q <= wcnt_d;
  end
`else
  assign wc = 16'd0;
`endif

  always_comb begin
    pend_d     = pend_q;
    pa_d       = pa_q;
    pb_d       = pb_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    done_d     = answer;
    result_d   = '0;
    state_d    = state_q;
    op_d       = op_q;
    reg_en_d   = 1'b0;
    mem_en_d   = 1'b0;
    reg_sel_d  = reg_sel_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    if (!pend_q && start) begin
      pend_d = 1'b1;
      pa_d   = dataA;
      pb_d   = dataB;
    end else if (answer) begin
      pend_d = 1'b0;
    end
    if (pend_q && is_stat)
      result_d = {wc, 8'(count_q), 5'd0, full, empty, state_q != IDLE};
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case (state_q)
      IDLE: if (!empty) state_d = LOAD;
      LOAD: begin
        op_d       = head_a[1:0];
        reg_sel_d  = head_a[1];
        reg_addr_d = head_a[8:4];
        reg_data_d = head_b;
        mem_addr_d = head_a[AW-1:4];
        mem_data_d = head_b[COLOR_W-1:0];
        state_d    = EXEC;
      end
      EXEC: begin
        // Register writes hold the head until vblank so the bank never tears.
        if (op_q == 2'b01) begin
          mem_en_d = 1'b1;
          state_d  = IDLE;
        end else if (vblank) begin
          reg_en_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= pa_q[AW-1:0];
      fifo_b_q[wr_ptr_q] <= pb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pa_q       <= '0;
      pb_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_q       <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
      reg_en_q   <= 1'b0;
      reg_sel_q  <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pa_q       <= pa_d;
      pb_q       <= pb_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_q       <= op_d;
      done_q     <= done_d;
      result_q   <= result_d;
      reg_en_q   <= reg_en_d;
      reg_sel_q  <= reg_sel_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign done        = done_q;
  assign result      = result_q;
  assign busy        = pend_q | ~empty | (state_q != IDLE);
  assign reg_wr_en   = reg_en_q;
  assign reg_wr_sel  = reg_sel_q;
  assign reg_wr_addr = reg_addr_q;
  assign reg_wr_data = reg_data_q;
  assign mem_wr_en   = mem_en_q;
  assign mem_wr_addr = mem_addr_q;
  assign mem_wr_data = mem_data_q;
endmodule
